// File: rtl/lv_scan_rd_arb.sv
// Register-file access arbiter for the watchdog scan reader and the SPI host.
// Scan reads return data plus a CRC-8 so the watchdog can detect corrupted contents.

module crc16to8_parallel (
  input  logic [15:0] data_i,
  output logic [7:0]  crc_o
);
  // CRC-8, polynomial x^8+x^2+x+1, zero init, MSB first.
  logic [7:0] c;

  always_comb begin
    c = 8'h00;
    for (int i = 15; i >= 0; i--) begin
      if (c[7] ^ data_i[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else                  c = {c[6:0], 1'b0};
    end
    crc_o = c;
  end
endmodule

module lv_scan_rd_arb #(
  parameter int unsigned REG_AW    = 7,
  parameter int unsigned REG_DW    = 8,
  parameter int unsigned REG_CRC_W = 8,
  parameter int unsigned RF_DEPTH  = 128,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wdg_scan_rd_req,
  input  logic [REG_AW-1:0]    i_wdg_scan_addr,
  output logic                 o_rac_wdg_scan_ack,
  output logic [REG_DW-1:0]    o_rac_wdg_scan_data,
  output logic [REG_CRC_W-1:0] o_rac_wdg_scan_crc,
  input  logic                 i_crc_inj,
  input  logic                 i_spi_rd_req,
  input  logic                 i_spi_wr_req,
  input  logic [REG_AW-1:0]    i_spi_addr,
  input  logic [REG_DW-1:0]    i_spi_wdata,
  output logic                 o_spi_ack,
  output logic [REG_DW-1:0]    o_spi_rdata,
  output logic                 o_spi_addr_err,
  output logic                 o_rf_rd_en,
  output logic                 o_rf_wr_en,
  output logic [REG_AW-1:0]    o_rf_addr,
  output logic [REG_DW-1:0]    o_rf_wdata,
  input  logic [REG_DW-1:0]    i_rf_rdata
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;
  localparam logic [1:0] StAck    = 2'd3;

  localparam logic MstWdg = 1'b0;
  localparam logic MstSpi = 1'b1;

  localparam logic [1:0] CntInit = 2'(RD_LAT - 1);

  logic [1:0]           state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic                 master_q, master_d;
  logic                 is_wr_q, is_wr_d;
  logic [REG_AW-1:0]    addr_q, addr_d;
  logic [REG_DW-1:0]    wdata_q, wdata_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 wdg_ack_q, wdg_ack_d;
  logic [REG_DW-1:0]    wdg_data_q, wdg_data_d;
  logic [REG_CRC_W-1:0] wdg_crc_q, wdg_crc_d;
  logic                 spi_ack_q, spi_ack_d;
  logic [REG_DW-1:0]    spi_rdata_q, spi_rdata_d;
  logic                 spi_err_q, spi_err_d;

  logic              spi_req;
  logic              grant_spi;
  logic              in_range;
  logic [REG_DW-1:0] cap_data;
  logic [15:0]       crc_msg;
  logic [7:0]        crc_raw;

  assign spi_req   = i_spi_rd_req | i_spi_wr_req;
  // A conflict goes to the master that lost the previous conflict.
  assign grant_spi = spi_req & (~i_wdg_scan_rd_req | (last_grant_q == MstWdg));
  assign in_range  = 32'(addr_q) < RF_DEPTH;
  assign cap_data  = in_range ? i_rf_rdata : '0;
  assign crc_msg   = {1'b1, addr_q, cap_data};

  crc16to8_parallel u_crc (
    .data_i(crc_msg),
    .crc_o (crc_raw)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    master_d     = master_q;
    is_wr_d      = is_wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    wdg_ack_d    = 1'b0;
    wdg_data_d   = wdg_data_q;
    wdg_crc_d    = wdg_crc_q;
    spi_ack_d    = 1'b0;
    spi_rdata_d  = spi_rdata_q;
    spi_err_d    = spi_err_q;
    case (state_q)
      StIdle: begin
        if (i_wdg_scan_rd_req | spi_req) begin
          state_d  = StAccess;
          master_d = grant_spi;
          addr_d   = grant_spi ? i_spi_addr : i_wdg_scan_addr;
          is_wr_d  = grant_spi & i_spi_wr_req;
          if (grant_spi) wdata_d = i_spi_wdata;
          if (i_wdg_scan_rd_req & spi_req) last_grant_d = grant_spi;
        end
      end
      StAccess: begin
        if (is_wr_q) begin
          state_d   = StAck;
          spi_ack_d = 1'b1;
          spi_err_d = ~in_range;
        end else begin
          state_d = StWait;
          cnt_d   = CntInit;
        end
      end
      StWait: begin
        if (cnt_q == 2'd0) begin
          state_d = StAck;
          if (master_q == MstSpi) begin
            spi_ack_d   = 1'b1;
            spi_rdata_d = cap_data;
            spi_err_d   = ~in_range;
          end else begin
            wdg_ack_d  = 1'b1;
            wdg_data_d = cap_data;
            wdg_crc_d  = crc_raw ^ {{(REG_CRC_W-1){1'b0}}, i_crc_inj};
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= MstSpi;
      master_q     <= MstWdg;
      is_wr_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= 2'd0;
      wdg_ack_q    <= 1'b0;
      wdg_data_q   <= '0;
      wdg_crc_q    <= '0;
      spi_ack_q    <= 1'b0;
      spi_rdata_q  <= '0;
      spi_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      master_q     <= master_d;
      is_wr_q      <= is_wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      wdg_ack_q    <= wdg_ack_d;
      wdg_data_q   <= wdg_data_d;
      wdg_crc_q    <= wdg_crc_d;
      spi_ack_q    <= spi_ack_d;
      spi_rdata_q  <= spi_rdata_d;
      spi_err_q    <= spi_err_d;
    end
  end

  assign o_rf_rd_en          = (state_q == StAccess) & ~is_wr_q & in_range;
  assign o_rf_wr_en          = (state_q == StAccess) & is_wr_q & in_range;
  assign o_rf_addr           = addr_q;
  assign o_rf_wdata          = wdata_q;
  assign o_rac_wdg_scan_ack  = wdg_ack_q;
  assign o_rac_wdg_scan_data = wdg_data_q;
  assign o_rac_wdg_scan_crc  = wdg_crc_q;
  assign o_spi_ack           = spi_ack_q;
  assign o_spi_rdata         = spi_rdata_q;
  assign o_spi_addr_err      = spi_err_q;

  logic req_held;
  assign req_held = (master_q == MstSpi) ? spi_req : i_wdg_scan_rd_req;

  a_req_held: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    ((state_q == StAccess) || (state_q == StWait)) |-> req_held);

endmodule

// File: tb/tb_lv_scan_rd_arb.sv
// Randomized bench for lv_scan_rd_arb with a transaction-level reference model.

module tb_lv_scan_rd_arb;
  localparam int unsigned AW    = 7;
  localparam int unsigned DW    = 8;
  localparam int unsigned CW    = 8;
  localparam int unsigned DEPTH = 100;
  localparam int unsigned LAT   = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wdg_req, wdg_ack, crc_inj;
  logic [AW-1:0] wdg_addr, spi_addr, rf_addr;
  logic [DW-1:0] wdg_data, spi_wdata, spi_rdata, rf_wdata, rf_rdata;
  logic [CW-1:0] wdg_crc;
  logic          spi_rd, spi_wr, spi_ack, spi_err, rf_rd_en, rf_wr_en;

  always #5 clk = ~clk;

  lv_scan_rd_arb #(
    .REG_AW(AW), .REG_DW(DW), .REG_CRC_W(CW), .RF_DEPTH(DEPTH), .RD_LAT(LAT)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_wdg_scan_rd_req  (wdg_req),
    .i_wdg_scan_addr    (wdg_addr),
    .o_rac_wdg_scan_ack (wdg_ack),
    .o_rac_wdg_scan_data(wdg_data),
    .o_rac_wdg_scan_crc (wdg_crc),
    .i_crc_inj          (crc_inj),
    .i_spi_rd_req       (spi_rd),
    .i_spi_wr_req       (spi_wr),
    .i_spi_addr         (spi_addr),
    .i_spi_wdata        (spi_wdata),
    .o_spi_ack          (spi_ack),
    .o_spi_rdata        (spi_rdata),
    .o_spi_addr_err     (spi_err),
    .o_rf_rd_en         (rf_rd_en),
    .o_rf_wr_en         (rf_wr_en),
    .o_rf_addr          (rf_addr),
    .o_rf_wdata         (rf_wdata),
    .i_rf_rdata         (rf_rdata)
  );

  function automatic logic [7:0] fill_val(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // Register file: rdata valid LAT cycles after the strobe, random junk otherwise.
  logic [DW-1:0]  rf_mem [128];
  logic [DW-1:0]  rd_pipe [LAT];
  logic [LAT-1:0] rd_vld;
  logic [DW-1:0]  junk;
  bit             mem_fill;

  always @(posedge clk) begin
    junk <= 8'($urandom);
    for (int i = LAT - 1; i > 0; i--) begin
      rd_pipe[i] <= rd_pipe[i-1];
      rd_vld[i]  <= rd_vld[i-1];
    end
    rd_pipe[0] <= rf_mem[rf_addr];
    rd_vld[0]  <= rf_rd_en;
    if (mem_fill) begin
      for (int i = 0; i < 128; i++) rf_mem[i] <= fill_val(i);
    end else if (rf_wr_en) begin
      rf_mem[rf_addr] <= rf_wdata;
    end
  end

  assign rf_rdata = rd_vld[LAT-1] ? rd_pipe[LAT-1] : junk;

  // Reference model state
  logic [DW-1:0] exp_mem [128];
  bit            last_spi;
  logic [DW-1:0] h_wdata, h_srdata;
  logic [CW-1:0] h_wcrc;
  bit            h_serr;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // CRC as the remainder of msg * x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_ref(input logic [15:0] msg);
    logic [23:0] r;
    r = {msg, 8'h00};
    for (int b = 23; b >= 8; b--) if (r[b]) r = r ^ (24'h107 << (b - 8));
    return r[7:0];
  endfunction

  function automatic bit in_range(input logic [AW-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  function automatic int lat_of(input bit wr);
    return wr ? 2 : int'(LAT) + 2;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_wack"}, wdg_ack, 0);
    check_eq({tag, "_wdata"}, wdg_data, 0);
    check_eq({tag, "_wcrc"}, wdg_crc, 0);
    check_eq({tag, "_sack"}, spi_ack, 0);
    check_eq({tag, "_srdata"}, spi_rdata, 0);
    check_eq({tag, "_serr"}, spi_err, 0);
    check_eq({tag, "_rd_en"}, rf_rd_en, 0);
    check_eq({tag, "_wr_en"}, rf_wr_en, 0);
    check_eq({tag, "_addr"}, rf_addr, 0);
    check_eq({tag, "_wdata_rf"}, rf_wdata, 0);
  endtask

  // Raise the requested masters together (called at a negedge) and check every cycle.
  task automatic run_txn(input bit w_req, input logic [AW-1:0] w_addr, input bit s_rd,
                         input bit s_wr, input logic [AW-1:0] s_addr,
                         input logic [DW-1:0] s_wdata, input bit inj);
    bit s_req, spi_first, exp_rd, exp_wr;
    int w_str, w_ack, s_str, s_ack, last;
    s_req = s_rd | s_wr;
    w_str = -1; w_ack = -1; s_str = -1; s_ack = -1;
    if (w_req && s_req) begin
      spi_first = !last_spi;
      last_spi  = spi_first;
    end else begin
      spi_first = s_req;
    end
    if (spi_first) begin
      s_str = 1; s_ack = lat_of(s_wr);
      if (w_req) begin w_str = s_ack + 2; w_ack = s_ack + 1 + lat_of(1'b0); end
    end else begin
      w_str = 1; w_ack = lat_of(1'b0);
      if (s_req) begin s_str = w_ack + 2; s_ack = w_ack + 1 + lat_of(s_wr); end
    end
    last = (w_ack > s_ack) ? w_ack : s_ack;

    wdg_req = w_req; wdg_addr = w_addr; crc_inj = inj;
    spi_rd = s_rd; spi_wr = s_wr; spi_addr = s_addr; spi_wdata = s_wdata;

    for (int k = 1; k <= last + 2; k++) begin
      @(negedge clk);
      exp_rd = 1'b0; exp_wr = 1'b0;
      if (k == w_str && in_range(w_addr)) begin
        exp_rd = 1'b1;
        check_eq("rf_addr_wdg", rf_addr, w_addr);
      end
      if (k == s_str && in_range(s_addr)) begin
        exp_rd = s_rd; exp_wr = s_wr;
        check_eq("rf_addr_spi", rf_addr, s_addr);
        if (s_wr) begin
          check_eq("rf_wdata", rf_wdata, s_wdata);
          exp_mem[s_addr] = s_wdata;
        end
      end
      check_eq("rf_rd_en", rf_rd_en, exp_rd);
      check_eq("rf_wr_en", rf_wr_en, exp_wr);
      if (k == w_ack) begin
        h_wdata = in_range(w_addr) ? exp_mem[w_addr] : '0;
        h_wcrc  = crc_ref({1'b1, w_addr, h_wdata}) ^ {7'd0, inj};
      end
      if (k == s_ack) begin
        if (s_rd) h_srdata = in_range(s_addr) ? exp_mem[s_addr] : '0;
        h_serr = !in_range(s_addr);
      end
      check_eq("wdg_ack", wdg_ack, k == w_ack);
      check_eq("spi_ack", spi_ack, k == s_ack);
      check_eq("wdg_data", wdg_data, h_wdata);
      check_eq("wdg_crc", wdg_crc, h_wcrc);
      check_eq("spi_rdata", spi_rdata, h_srdata);
      check_eq("spi_addr_err", spi_err, h_serr);
      // Requests drop one cycle after the ack, as a registered requester would.
      if (k == w_ack + 1) wdg_req = 1'b0;
      if (k == s_ack + 1) begin spi_rd = 1'b0; spi_wr = 1'b0; end
    end
  endtask

  task automatic reset_in_wait();
    wdg_req = 1'b1; wdg_addr = 7'h21; crc_inj = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_wait");
    wdg_req  = 1'b0;
    h_wdata  = '0; h_wcrc = '0; h_srdata = '0; h_serr = 1'b0;
    last_spi = 1'b1;
    @(negedge clk);
    check_all_zero("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(1'b1, 7'h21, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    int t;
    bit wq;
    mem_fill = 1'b1;
    rst_n = 1'b0;
    wdg_req = 1'b0; wdg_addr = '0; crc_inj = 1'b0;
    spi_rd = 1'b0; spi_wr = 1'b0; spi_addr = '0; spi_wdata = '0;
    for (int i = 0; i < 128; i++) exp_mem[i] = fill_val(i);
    last_spi = 1'b1;
    h_wdata = '0; h_wcrc = '0; h_srdata = '0; h_serr = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    mem_fill = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1'b0, '0, 1'b0, 1'b1, 7'h0B, 8'h3C, 1'b0);
    run_txn(1'b0, '0, 1'b0, 1'b1, 7'h30, 8'hA5, 1'b0);
    run_txn(1'b1, 7'h30, 1'b0, 1'b0, '0, '0, 1'b0);
    run_txn(1'b1, 7'h30, 1'b0, 1'b0, '0, '0, 1'b1);
    run_txn(1'b1, 7'h12, 1'b1, 1'b0, 7'h0B, '0, 1'b0);
    run_txn(1'b1, 7'h0B, 1'b1, 1'b0, 7'h30, '0, 1'b0);
    run_txn(1'b0, '0, 1'b1, 1'b0, 7'h7F, '0, 1'b0);
    run_txn(1'b1, 7'h70, 1'b0, 1'b1, 7'h65, 8'hEE, 1'b1);
    reset_in_wait();

    repeat (300) begin
      wq = 1'($urandom_range(0, 1));
      t  = int'($urandom_range(0, 2));
      if (!wq && t == 0) wq = 1'b1;
      run_txn(wq, 7'($urandom), t == 1, t == 2, 7'($urandom), 8'($urandom),
              1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lv_scan_rd_arb.md
# lv_scan_rd_arb

Register-access arbiter for the LV register file. It sits directly upstream of `lv_wdg_ctrl` and serves two masters over one register-file port: the watchdog scan reader and the SPI host. Watchdog scan reads return data plus a CRC-8 over `{1'b1, addr, data}` so that `lv_wdg_ctrl` can detect corrupted register contents. A BIST injection input can corrupt that CRC on purpose to exercise the scan-error path.

## Interface
- `REG_AW`, 7, register address width
- `REG_DW`, 8, register data width
- `REG_CRC_W`, 8, CRC width
- `RF_DEPTH`, 128, number of implemented addresses; addresses `>= RF_DEPTH` are out of range
- `RD_LAT`, 1, register-file read latency in cycles (1..3)
- `i_clk`  in  1  clock; the only clock in the block
- `i_rst_n`  in  1  asynchronous, active-low reset
- `i_wdg_scan_rd_req`  in  1  watchdog scan read request; level, held until ack
- `i_wdg_scan_addr`  in  REG_AW  scan address; stable while the request is high
- `o_rac_wdg_scan_ack`  out  1  one-cycle pulse; data and CRC are valid in this cycle
- `o_rac_wdg_scan_data`  out  REG_DW  scan read data; held until the next scan ack
- `o_rac_wdg_scan_crc`  out  REG_CRC_W  CRC-8 of `{1'b1, addr, data}`; held
- `i_crc_inj`  in  1  BIST: invert bit 0 of the CRC returned for scan reads
- `i_spi_rd_req`, `i_spi_wr_req`  in  1 each  SPI request levels, held until ack; never both high
- `i_spi_addr`  in  REG_AW  SPI address
- `i_spi_wdata`  in  REG_DW  SPI write data
- `o_spi_ack`  out  1  one-cycle pulse
- `o_spi_rdata`  out  REG_DW  SPI read data, held
- `o_spi_addr_err`  out  1  valid with `o_spi_ack`: the address was out of range
- `o_rf_rd_en`, `o_rf_wr_en`  out  1 each  register-file strobes, one cycle
- `o_rf_addr`  out  REG_AW  register-file address
- `o_rf_wdata`  out  REG_DW  register-file write data
- `i_rf_rdata`  in  REG_DW  read data, valid `RD_LAT` cycles after `o_rf_rd_en`

## Operation
- **FSM states:**
  - IDLE: sample requests.
  - ACCESS: strobe the register file for one cycle.
  - WAIT: count `RD_LAT` cycles; skipped for writes.
  - ACK: drive the one-cycle ack.
  - The ACK state always returns to IDLE.
- **Arbitration in IDLE:**
  - If only one master requests, grant it.
  - If both request, grant the master not served last (round-robin). A one-bit `last_grant` register holds this; its reset value is SPI, so the first conflict goes to the watchdog.
- **Grant capture:** at grant, latch the master, the address, the write data and the read/write type.
- **ACCESS:**
  - `o_rf_addr` is the latched address.
  - For a read, pulse `o_rf_rd_en`; for a write, pulse `o_rf_wr_en` with `o_rf_wdata`.
  - If the address is out of range, no strobe is issued. Reads return 0 and writes are dropped.
- **Data and CRC capture:** `i_rf_rdata` (or 0 when out of range) is captured at the end of WAIT.
  - For the watchdog, the CRC is computed by instantiating `crc16to8_parallel` on `{1'b1, addr, data}`.
  - `i_crc_inj` is XORed into bit 0 at capture.
  - Watchdog scan writes do not exist.
- **Ack timing:** the ack goes only to the granted master, in ACK.
- **No re-grant:** requests are not sampled in ACK. This prevents re-granting a request level that drops one cycle after ack.
- **Watchdog out-of-range reads:** the CRC is still computed, on data 0. No error is flagged to the watchdog.
- **Reset values:**
  - All outputs 0.
  - FSM in IDLE.
  - `last_grant` = SPI.
  - Reset mid-transaction aborts it with no ack; the held outputs clear.

## Timing
- Cycle 0: request seen in IDLE.
- Cycle 1: ACCESS (strobe high).
- Cycles 2..RD_LAT+1: WAIT (reads only).
- Ack cycle:
  - Read: cycle `RD_LAT+2`. With `RD_LAT=1`, the ack is in cycle 3.
  - Write: cycle 2.
- Back-to-back: the next grant is possible in the cycle after ACK. Scan read throughput is one read per `RD_LAT+3` cycles.
- Ack outputs, data, CRC and `o_spi_addr_err` are registered. They are stable from the ack cycle until the next capture.
- Dropping a request before ack is illegal (checked by assertion). The block still completes the transaction and pulses the ack.

## Test plan
- Watchdog read only, addr 7'h30, `i_rf_rdata`=8'hA5, `RD_LAT`=1 → `o_rf_rd_en` in cycle 1, ack in cycle 3, data 8'hA5, CRC equal to the `crc16to8_parallel` model of 16'hB0A5.
- Same read with `i_crc_inj`=1 → CRC equals the model value with bit 0 flipped. A downstream `lv_wdg_ctrl` flags `o_wdg_scan_crc_err` one cycle later.
- Watchdog and SPI read both raised at cycle 0 → watchdog served first (acks in cycle 3), SPI served next (ack in cycle 7). Raising both again afterwards gives SPI first.
- SPI write addr 7'h0B, data 8'h3C → `o_rf_wr_en` with 7'h0B/8'h3C in cycle 1, `o_spi_ack` in cycle 2, `o_spi_addr_err`=0.
- SPI read addr 7'h7F with `RF_DEPTH`=100 → no `o_rf_rd_en`, `o_spi_rdata`=0, `o_spi_addr_err`=1 with the ack.
- `i_rst_n` asserted in WAIT → no ack, all outputs 0. After release, a new watchdog request is served with nominal latency.
